dac_wavegen: RTL



---
 rtl/dac_wavegen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dac_wavegen.sv
// Waveform generator and pin driver for the parallel-input DAC: phase accumulator,
// three-stage code pipeline, shadowed configuration applied at the period wrap.
//
// state    | meaning
// DISABLED | waveform stopped, dac_da holds IDLE_CODE, a pending shadow applies next cycle
// RUN      | waveform running, no shadow config waiting
// PEND     | waveform running, shadow config waits for the phase wrap (or active step 0)
module dac_wavegen #(
    parameter int          DATA_W          = 8,
    parameter int          PHASE_W         = 32,
    parameter int unsigned IDLE_CODE       = 178,
    parameter bit          SLEEP_WHEN_IDLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DATA_W-1:0]  cfg_amp,
    input  logic [DATA_W-1:0]  cfg_offset,
    output logic               sync,
    output logic               dac_mode,
    output logic               dac_clka,
    output logic               dac_wra,
    output logic               dac_sleep,
    output logic [DATA_W-1:0]  dac_da
);

    localparam logic [DATA_W-1:0] IDLE = IDLE_CODE[DATA_W-1:0];

    typedef enum logic [1:0] {DISABLED, RUN, PEND} state_t;

    state_t state, state_nxt;

    logic [2:0]         act_mode, sh_mode;
    logic [PHASE_W-1:0] act_step, sh_step;
    logic [DATA_W-1:0]  act_amp, sh_amp;
    logic [DATA_W-1:0]  act_offset, sh_offset;
    logic               sh_valid;

    logic [PHASE_W-1:0] phase;
    logic               v1, w1, v2, w2;
    logic [DATA_W-1:0]  s2, off2;

    logic               xfer, running, wrap_now, apply;
    logic [PHASE_W:0]   phase_sum;
    logic [DATA_W:0]    t;
    logic [DATA_W-1:0]  raw;
    logic [DATA_W:0]    out_sum;

    assign cfg_ready = ~sh_valid;
    assign xfer      = cfg_valid & cfg_ready;
    assign running   = (state != DISABLED) && enable;
    assign phase_sum = {1'b0, phase} + {1'b0, act_step};
    assign wrap_now  = running && v1 && phase_sum[PHASE_W];

    always_ff @(posedge clk) begin
        if (rst) state <= DISABLED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            DISABLED: begin
                apply = sh_valid;
                if (enable) state_nxt = xfer ? PEND : RUN;
            end
            RUN: begin
                if (!enable)   state_nxt = DISABLED;
                else if (xfer) state_nxt = PEND;
            end
            PEND: begin
                if (!enable) begin
                    state_nxt = DISABLED;
                end else if (wrap_now || (act_step == '0)) begin
                    apply     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_valid   <= 1'b0;
            sh_mode    <= '0;
            sh_step    <= '0;
            sh_amp     <= '0;
            sh_offset  <= '0;
            act_mode   <= '0;
            act_step   <= '0;
            act_amp    <= '0;
            act_offset <= IDLE;
        end else begin
            if (xfer) begin
                sh_valid  <= 1'b1;
                sh_mode   <= cfg_mode;
                sh_step   <= cfg_step;
                sh_amp    <= cfg_amp;
                sh_offset <= cfg_offset;
            end else if (apply) begin
                sh_valid  <= 1'b0;
            end
            if (apply) begin
                act_mode   <= sh_mode;
                act_step   <= sh_step;
                act_amp    <= sh_amp;
                act_offset <= sh_offset;
            end
        end
    end

    assign t = phase[PHASE_W-1 -: DATA_W+1];

    always_comb begin
        raw = '0;
        case (act_mode)
            3'd1:    raw = t[DATA_W:1];
            3'd2:    raw = t[DATA_W] ? ~t[DATA_W-1:0] : t[DATA_W-1:0];
            3'd3:    raw = {DATA_W{phase[PHASE_W-1]}};
            default: raw = '0;
        endcase
    end

    assign out_sum = {1'b0, off2} + {1'b0, s2};

    // Offset travels with the product so a config switch never mixes old and new fields.
    always_ff @(posedge clk) begin
        if (rst || !running) begin
            phase  <= '0;
            v1     <= 1'b0;
            w1     <= 1'b0;
            v2     <= 1'b0;
            w2     <= 1'b0;
            s2     <= '0;
            off2   <= IDLE;
            dac_da <= IDLE;
            sync   <= 1'b0;
        end else begin
            v1 <= 1'b1;
            if (v1) begin
                phase <= phase_sum[PHASE_W-1:0];
                w1    <= phase_sum[PHASE_W];
            end else begin
                phase <= '0;
                w1    <= 1'b1;
            end
            v2     <= v1;
            w2     <= w1;
            s2     <= DATA_W'(({{DATA_W{1'b0}}, raw} * {{DATA_W{1'b0}}, act_amp}) >> DATA_W);
            off2   <= act_offset;
            dac_da <= v2 ? (out_sum[DATA_W] ? {DATA_W{1'b1}} : out_sum[DATA_W-1:0]) : IDLE;
            sync   <= v2 & w2;
        end
    end

    assign dac_mode  = 1'b1;
    assign dac_clka  = ~clk;
    assign dac_wra   = dac_clka;
    assign dac_sleep = SLEEP_WHEN_IDLE && (state == DISABLED);

endmodule
